output_port_allocator: RTL and testbench
========================================

# output_port_allocator

Per-output-port allocator that sits in front of one output reduction tree of the router switch. It picks one of `FAN_IN` input VCs requesting this output using round-robin order. It holds the grant for the whole packet, from head flit to tail flit, and gates every transfer on a downstream credit counter. One instance is used per output direction: XPOS, YPOS, ZPOS, XNEG, YNEG, ZNEG.

## Interface
Parameters:
- `FAN_IN`, default 12: number of requesting input VCs (VC_NUM * PORT_NUM).
- `CREDIT_MAX`, default 8: downstream buffer depth in flits, which is also the reset credit count.
- `IDX_W`, default `$clog2(FAN_IN)`: width of the owner index.
- `CNT_W`, default `$clog2(CREDIT_MAX+1)`: width of the credit counter.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  FAN_IN: bit i is high when VC i has a flit at its head that is routed to this output.
- `tail`  in  FAN_IN: bit i is high when the head flit of VC i is the last flit of its packet. Only meaningful when `req[i]` is high.
- `credit_in`  in  1: one credit returned by the downstream hop this cycle.
- `gnt`  out  FAN_IN: one-hot or zero. Bit i high means VC i's flit transfers this cycle.
- `fire`  out  1: equals `|gnt`; drives the reduction tree's valid for this output.
- `locked`  out  1: a packet is in progress and the allocator is in state LOCKED.
- `owner`  out  IDX_W: index of the VC holding the lock; 0 when not locked.
- `credits`  out  CNT_W: current credit count.
- `err_credit_ovf`  out  1: sticky; set when `credit_in` arrives while the effective count would exceed `CREDIT_MAX`.

## Operation
- The state machine has two states, IDLE and LOCKED. Registers: `state`, `owner`, round-robin pointer `ptr` (IDX_W bits), `credits`, `err_credit_ovf`.
- `has_credit` = (`credits` != 0), evaluated on the registered value.
- `gnt` in IDLE:
  - If `has_credit`, grant the first set bit of `req` searching from `ptr` upward and wrapping past FAN_IN-1 to 0.
  - If `has_credit` is low or `req` is 0, `gnt` = 0.
- `gnt` in LOCKED:
  - `gnt` = one-hot(`owner`) when `req[owner]` and `has_credit` are both high; otherwise 0.
  - Requests from other VCs are ignored.
- Transitions when `fire` is high with winner w:
  - IDLE, `tail[w]`=1 (single-flit packet): stay IDLE; `ptr` <= w+1, wrapping FAN_IN to 0.
  - IDLE, `tail[w]`=0: go to LOCKED; `owner` <= w.
  - LOCKED, `tail[owner]`=1: go to IDLE; `ptr` <= owner+1 with wrap; `owner` <= 0.
  - LOCKED, `tail[owner]`=0: stay LOCKED.
- When `fire` is low, state, `owner` and `ptr` hold their values.
- Credit update rules:
  - `fire` && !`credit_in`: `credits` - 1.
  - !`fire` && `credit_in`: `credits` + 1, saturating at `CREDIT_MAX`. If `credits` == `CREDIT_MAX`, the count stays and `err_credit_ovf` <= 1.
  - Both high: `credits` unchanged.
  - Neither: unchanged.
  - `credits` never underflows, because `fire` requires `has_credit`.
- `err_credit_ovf` is cleared only by `rst`.

## Timing
- Grant latency is 0 cycles: `gnt` and `fire` are combinational from `req`, `tail` and the registered state.
- State, `ptr`, `owner`, `credits` and `locked` reflect a transfer from the next cycle.
- A credit returned in cycle t cannot enable a transfer in cycle t; it can be used from cycle t+1.
- Throughput is 1 flit per cycle while credits last. A packet of L flits with no stalls occupies the output for exactly L consecutive cycles.
- A stall while LOCKED (`req[owner]`=0 or `credits`=0) keeps the lock; the output is not reassigned mid-packet.
- Reset values, which take effect on the rising edge with `rst`=1 and apply mid-packet as well:
  - state IDLE, `ptr`=0, `owner`=0, `locked`=0.
  - `credits`=`CREDIT_MAX`, `err_credit_ovf`=0.
  - `gnt`=0 and `fire`=0 during the reset cycle.

## Test plan
- Round-robin fairness: after reset, `req`=0b1111 with `tail`=0b1111 held for 4 cycles, `credit_in` pulsed every cycle. Required `gnt` sequence: 0x1, 0x2, 0x4, 0x8; `credits` stays at 8.
- Packet lock: VC3 sends a 3-flit packet (tail on flit 3) while `req[5]` is high throughout. Required: `gnt`=0x008 for 3 consecutive cycles, then 0x020; `locked` is high for the 2 cycles after the first grant.
- Credit exhaustion: `CREDIT_MAX`=8 and VC0 streams 10 single-flit packets with no `credit_in`. Required: 8 fires, then `fire`=0 and `credits`=0. One `credit_in` pulse then produces exactly one fire on the next cycle.
- Simultaneous fire and credit return: with `credits`=4, `fire` and `credit_in` high in the same cycle. Required: `credits` remains 4.
- Credit overflow: `credit_in` pulsed while `credits`=8 with no fire. Required: `credits` stays 8 and `err_credit_ovf`=1, which persists until `rst`.
- Reset mid-packet: assert `rst` while LOCKED on VC7 with `credits`=2. Required next cycle: `locked`=0, `owner`=0, `credits`=8. With `req`=0x880, the next grant is 0x080 because the search starts at `ptr`=0.

Source files
------------

// File: rtl/output_port_allocator.sv
// Per-output round-robin allocator: holds the output for a whole packet (head to tail)
// and gates every flit transfer on a downstream credit counter.
module output_port_allocator #(
  parameter int unsigned FAN_IN     = 12,
  parameter int unsigned CREDIT_MAX = 8,
  parameter int unsigned IDX_W      = $clog2(FAN_IN),
  parameter int unsigned CNT_W      = $clog2(CREDIT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FAN_IN-1:0] req,
  input  logic [FAN_IN-1:0] tail,
  input  logic              credit_in,
  output logic [FAN_IN-1:0] gnt,
  output logic              fire,
  output logic              locked,
  output logic [IDX_W-1:0]  owner,
  output logic [CNT_W-1:0]  credits,
  output logic              err_credit_ovf
);

  localparam int unsigned      LAST_IDX = FAN_IN - 1;
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDIT_MAX);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_credits;
  logic               r_err_ovf;

  logic               w_has_credit;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  int unsigned        w_idx;
  logic [FAN_IN-1:0]  w_gnt;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_sel_inc;
  logic               w_fire;
  logic               w_tail;

  assign w_has_credit = (r_credits != '0);

  // Round-robin search: first requester at or above r_ptr, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < FAN_IN; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= FAN_IN) w_idx = w_idx - FAN_IN;
      if (!w_found && req[IDX_W'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  // Grant selection; a locked output only ever serves its owner.
  always_comb begin
    w_gnt = '0;
    w_sel = '0;
    if (!rst && w_has_credit) begin
      if (r_state == ST_IDLE) begin
        if (w_found) begin
          w_gnt[w_win] = 1'b1;
          w_sel        = w_win;
        end
      end else if (req[r_owner]) begin
        w_gnt[r_owner] = 1'b1;
        w_sel          = r_owner;
      end
    end
    w_fire    = |w_gnt;
    w_tail    = tail[w_sel];
    w_sel_inc = (w_sel == IDX_W'(LAST_IDX)) ? '0 : w_sel + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_credits <= CRED_MAX;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_tail) begin
          r_state <= ST_IDLE;
          r_ptr   <= w_sel_inc;
          r_owner <= '0;
        end else begin
          r_state <= ST_LOCKED;
          r_owner <= w_sel;
        end
      end

      // A transfer and a returned credit in the same cycle cancel out.
      case ({w_fire, credit_in})
        2'b10: r_credits <= r_credits - CNT_W'(1);
        2'b01: begin
          if (r_credits == CRED_MAX) r_err_ovf <= 1'b1;
          else                       r_credits <= r_credits + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt            = w_gnt;
  assign fire           = w_fire;
  assign locked         = (r_state == ST_LOCKED);
  assign owner          = r_owner;
  assign credits        = r_credits;
  assign err_credit_ovf = r_err_ovf;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: round-robin, packet lock, credits, overflow, reset.
module tb_output_port_allocator;

  localparam int unsigned FAN_IN = 12;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [FAN_IN-1:0] req;
  logic [FAN_IN-1:0] tail;
  logic              credit_in;
  logic [FAN_IN-1:0] gnt;
  logic              fire;
  logic              locked;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  credits;
  logic              err_credit_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  output_port_allocator #(.FAN_IN(12), .CREDIT_MAX(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .tail           (tail),
    .credit_in      (credit_in),
    .gnt            (gnt),
    .fire           (fire),
    .locked         (locked),
    .owner          (owner),
    .credits        (credits),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs shortly after an edge and let the combinational grant settle.
  task automatic drive(input logic r, input logic [FAN_IN-1:0] rq,
                       input logic [FAN_IN-1:0] tl, input logic cr);
    rst       = r;
    req       = rq;
    tail      = tl;
    credit_in = cr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, '0, '0, 1'b0);
    tick();
  endtask

  logic [FAN_IN-1:0] rr_exp [4];

  initial begin
    rr_exp[0] = 12'h001;
    rr_exp[1] = 12'h002;
    rr_exp[2] = 12'h004;
    rr_exp[3] = 12'h008;

    // Reset: outputs gated low during the reset cycle even with requests present.
    drive(1'b1, 12'hFFF, 12'hFFF, 1'b0);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_fire", 32'(fire), 32'h0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_credits", 32'(credits), 32'd8);
    check_eq("rst_err", 32'(err_credit_ovf), 32'h0);

    // Round-robin over four single-flit requesters, credit returned each cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 12'h00F, 12'h00F, 1'b1);
      check_eq($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
      tick();
      check_eq($sformatf("rr_cred%0d", i), 32'(credits), 32'd8);
    end

    // Packet lock: VC3 three-flit packet while VC5 keeps requesting.
    do_reset();
    drive(1'b0, 12'h028, 12'h000, 1'b0);
    check_eq("pkt_gnt0", 32'(gnt), 32'h008);
    tick();
    check_eq("pkt_locked0", 32'(locked), 32'h1);
    check_eq("pkt_owner0", 32'(owner), 32'd3);
    drive(1'b0, 12'h028, 12'h000, 1'b0);
    check_eq("pkt_gnt1", 32'(gnt), 32'h008);
    tick();
    check_eq("pkt_locked1", 32'(locked), 32'h1);
    drive(1'b0, 12'h028, 12'h008, 1'b0);
    check_eq("pkt_gnt2", 32'(gnt), 32'h008);
    tick();
    check_eq("pkt_unlocked", 32'(locked), 32'h0);
    check_eq("pkt_owner_clr", 32'(owner), 32'h0);
    drive(1'b0, 12'h020, 12'h020, 1'b0);
    check_eq("pkt_gnt_vc5", 32'(gnt), 32'h020);
    tick();
    check_eq("pkt_credits", 32'(credits), 32'd4);

    // Simultaneous fire and credit return at credits=4 (ptr=6, search wraps to VC0).
    drive(1'b0, 12'h001, 12'h001, 1'b1);
    check_eq("sim_gnt", 32'(gnt), 32'h001);
    tick();
    check_eq("sim_credits", 32'(credits), 32'd4);

    // Credit exhaustion: ten single-flit packets from VC0, no credits returned.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 12'h001, 12'h001, 1'b0);
      check_eq($sformatf("exh_fire%0d", i), 32'(fire), (i < 8) ? 32'h1 : 32'h0);
      tick();
    end
    check_eq("exh_credits", 32'(credits), 32'd0);
    drive(1'b0, 12'h001, 12'h001, 1'b1);
    check_eq("exh_ret_same_cycle", 32'(fire), 32'h0);
    tick();
    check_eq("exh_cred_one", 32'(credits), 32'd1);
    drive(1'b0, 12'h001, 12'h001, 1'b0);
    check_eq("exh_ret_fire", 32'(fire), 32'h1);
    tick();
    drive(1'b0, 12'h001, 12'h001, 1'b0);
    check_eq("exh_again_stall", 32'(fire), 32'h0);
    check_eq("exh_cred_zero", 32'(credits), 32'd0);
    tick();

    // Credit overflow: return while full, sticky until reset.
    do_reset();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check_eq("ovf_credits", 32'(credits), 32'd8);
    check_eq("ovf_err", 32'(err_credit_ovf), 32'h1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    check_eq("ovf_sticky", 32'(err_credit_ovf), 32'h1);
    do_reset();
    check_eq("ovf_cleared", 32'(err_credit_ovf), 32'h0);

    // Reset mid-packet: lock on VC7, drain to credits=2, stall, then reset.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 12'h080, 12'h000, 1'b0);
      tick();
    end
    check_eq("mid_locked", 32'(locked), 32'h1);
    check_eq("mid_owner", 32'(owner), 32'd7);
    check_eq("mid_credits", 32'(credits), 32'd2);
    drive(1'b0, 12'h800, 12'h800, 1'b0);
    check_eq("stall_gnt", 32'(gnt), 32'h0);
    tick();
    check_eq("stall_locked", 32'(locked), 32'h1);
    check_eq("stall_credits", 32'(credits), 32'd2);
    drive(1'b1, 12'h080, 12'h000, 1'b0);
    check_eq("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    drive(1'b0, 12'h880, 12'h880, 1'b0);
    check_eq("post_rst_locked", 32'(locked), 32'h0);
    check_eq("post_rst_owner", 32'(owner), 32'h0);
    check_eq("post_rst_credits", 32'(credits), 32'd8);
    check_eq("post_rst_gnt", 32'(gnt), 32'h080);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
